// File: rtl/step_phase_sequencer_pkg.sv
// Shared stepper definitions: direction and step-size encodings, coil bit
// positions, and the eight-entry half-step energisation table.
package stepper_pkg;

  typedef logic [2:0] phase_t;
  typedef logic [3:0] coils_t;

  typedef enum logic {
    DIR_REV = 1'b0,
    DIR_FWD = 1'b1
  } dir_e;

  // Same polarity as the quarter-turn block's step size key.
  typedef enum logic {
    STEP_HALF = 1'b0,
    STEP_FULL = 1'b1
  } step_size_e;

  localparam int COIL_A    = 0;
  localparam int COIL_B    = 1;
  localparam int COIL_ABAR = 2;
  localparam int COIL_BBAR = 3;

  // Even phases drive one coil, odd phases drive the two neighbouring coils.
  localparam coils_t PHASE_TABLE [8] = '{
    coils_t'(1 << COIL_A),
    coils_t'((1 << COIL_A)    | (1 << COIL_B)),
    coils_t'(1 << COIL_B),
    coils_t'((1 << COIL_B)    | (1 << COIL_ABAR)),
    coils_t'(1 << COIL_ABAR),
    coils_t'((1 << COIL_ABAR) | (1 << COIL_BBAR)),
    coils_t'(1 << COIL_BBAR),
    coils_t'((1 << COIL_BBAR) | (1 << COIL_A))
  };

endpackage

// File: rtl/step_phase_sequencer_if.sv
// Control and status bundle between a step source and the phase sequencer.
interface step_phase_sequencer_if #(
  parameter int POS_W = 16
);
  logic             step;
  logic             dir;
  logic             full_step;
  logic             enable;
  logic [3:0]       coils;
  logic             energized;
  logic             step_done;
  logic [POS_W-1:0] position;

  modport master (
    output step, dir, full_step, enable,
    input  coils, energized, step_done, position
  );

  modport slave (
    input  step, dir, full_step, enable,
    output coils, energized, step_done, position
  );
endinterface

// File: rtl/step_phase_sequencer_phase_lut.sv
// Combinational phase index to coil pattern lookup.
module phase_lut
  import stepper_pkg::*;
(
  input  phase_t i_phase,
  output coils_t o_coils
);

  // NOTE: a full 8-entry index into a constant table covers every input
  // value, so no path is left unassigned and no latch can be inferred.
  always_comb begin
    o_coils = PHASE_TABLE[i_phase];
  end

endmodule

// File: rtl/step_phase_sequencer.sv
// Step phase sequencer: turns gated step pulses into coil patterns for a
// 4-wire stepper driver, with position tracking and idle de-energise.
module step_phase_sequencer
  import stepper_pkg::*;
#(
  parameter int                POS_W       = 16,
  parameter int                IDLE_W      = 24,
  parameter logic [IDLE_W-1:0] IDLE_CYCLES = 24'd5_000_000
) (
  input logic                   clk,
  input logic                   rst,
  step_phase_sequencer_if.slave bus
);

  localparam bit                IDLE_EN   = (IDLE_CYCLES != '0);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_CYCLES - 1'b1;

  logic              r_step_q;
  phase_t            r_phase;
  coils_t            r_coils;
  logic              r_energized;
  logic              r_step_done;
  logic [POS_W-1:0]  r_position;
  logic [IDLE_W-1:0] r_idle_cnt;

  logic              w_step_rise;
  logic              w_accept;
  logic              w_fwd;
  logic              w_timeout;
  phase_t            w_phase_delta;
  phase_t            w_next_phase;
  coils_t            w_next_coils;
  logic [POS_W-1:0]  w_pos_delta;
  logic [POS_W-1:0]  w_next_position;

  // step is already in the clk domain, so a single register suffices.
  assign w_step_rise   = bus.step & ~r_step_q;
  assign w_accept      = w_step_rise & bus.enable;
  assign w_fwd         = (bus.dir == DIR_FWD);
  assign w_phase_delta = (bus.full_step == STEP_FULL) ? 3'd2 : 3'd1;
  assign w_pos_delta   = POS_W'(w_phase_delta);

  assign w_next_phase    = w_fwd ? r_phase + w_phase_delta : r_phase - w_phase_delta;
  assign w_next_position = w_fwd ? r_position + w_pos_delta : r_position - w_pos_delta;
  assign w_timeout       = IDLE_EN && r_energized && (r_idle_cnt == IDLE_LAST);

  phase_lut u_phase_lut (
    .i_phase (w_next_phase),
    .o_coils (w_next_coils)
  );

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step_q    <= 1'b0;
      r_phase     <= '0;
      r_coils     <= '0;
      r_energized <= 1'b0;
      r_step_done <= 1'b0;
      r_position  <= '0;
      r_idle_cnt  <= '0;
    end else begin
      r_step_q    <= bus.step;
      r_step_done <= w_accept;
      if (!bus.enable) begin
        r_coils     <= '0;
        r_energized <= 1'b0;
        r_idle_cnt  <= '0;
      end else if (w_accept) begin
        // An accepted step outranks a coincident idle terminal count.
        r_phase     <= w_next_phase;
        r_position  <= w_next_position;
        r_coils     <= w_next_coils;
        r_energized <= 1'b1;
        r_idle_cnt  <= '0;
      end else if (w_timeout) begin
        r_coils     <= '0;
        r_energized <= 1'b0;
        r_idle_cnt  <= '0;
      end else if (r_energized) begin
        r_idle_cnt  <= r_idle_cnt + 1'b1;
      end
    end
  end

  assign bus.coils     = r_coils;
  assign bus.energized = r_energized;
  assign bus.step_done = r_step_done;
  assign bus.position  = r_position;

endmodule

// File: tb/tb_step_phase_sequencer.sv
// Self-checking bench: two sequencer instances (short idle timeout / narrow
// position) share one stimulus and are compared against a behavioural model.
module tb_step_phase_sequencer;

  logic clk;
  logic rst;
  logic s_step, s_dir, s_full, s_enable;

  int errors = 0;
  int checks = 0;

  step_phase_sequencer_if #(.POS_W(16)) bus_a ();
  step_phase_sequencer_if #(.POS_W(4))  bus_b ();

  assign bus_a.step = s_step;  assign bus_a.dir = s_dir;
  assign bus_a.full_step = s_full;  assign bus_a.enable = s_enable;
  assign bus_b.step = s_step;  assign bus_b.dir = s_dir;
  assign bus_b.full_step = s_full;  assign bus_b.enable = s_enable;

  step_phase_sequencer #(.POS_W(16), .IDLE_W(24), .IDLE_CYCLES(24'd10)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );

  step_phase_sequencer #(.POS_W(4), .IDLE_W(24), .IDLE_CYCLES(24'd0)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, one slot per instance: 0 = dut_a, 1 = dut_b.
  int         idle_limit [2] = '{10, 0};
  int         pos_mask   [2] = '{32'hFFFF, 32'hF};
  int         m_phase [2];
  int         m_pos   [2];
  int         m_idle  [2];
  logic [3:0] m_coils [2];
  logic       m_en    [2];
  logic       m_done  [2];
  logic       m_stepq [2];

  // Half-step sequence: even phase = coil phase/2 alone, odd phase = that
  // coil plus the next one round the ring A,B,Abar,Bbar.
  function automatic logic [3:0] pattern(input int ph);
    logic [3:0] p;
    p = 4'b0000;
    p[(ph / 2) % 4] = 1'b1;
    if (ph % 2 == 1) p[((ph + 1) / 2) % 4] = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_pos[k] = 0; m_idle[k] = 0;
      m_coils[k] = 4'b0000; m_en[k] = 1'b0; m_done[k] = 1'b0; m_stepq[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic rise;
      int   d;
      rise       = s_step && !m_stepq[k];
      m_stepq[k] = s_step;
      m_done[k]  = 1'b0;
      if (!s_enable) begin
        m_coils[k] = 4'b0000; m_en[k] = 1'b0; m_idle[k] = 0;
      end else if (rise) begin
        d = s_full ? 2 : 1;
        if (!s_dir) d = -d;
        m_phase[k] = (m_phase[k] + d + 8) % 8;
        m_pos[k]   = (m_pos[k] + d) & pos_mask[k];
        m_coils[k] = pattern(m_phase[k]);
        m_en[k]    = 1'b1;
        m_idle[k]  = 0;
        m_done[k]  = 1'b1;
      end else if (m_en[k]) begin
        if (idle_limit[k] != 0 && m_idle[k] == idle_limit[k] - 1) begin
          m_coils[k] = 4'b0000; m_en[k] = 1'b0; m_idle[k] = 0;
        end else begin
          m_idle[k] = m_idle[k] + 1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, " a.coils"},     32'(bus_a.coils),     32'(m_coils[0]));
    check({tag, " a.energized"}, 32'(bus_a.energized), 32'(m_en[0]));
    check({tag, " a.step_done"}, 32'(bus_a.step_done), 32'(m_done[0]));
    check({tag, " a.position"},  32'(bus_a.position),  32'(m_pos[0]));
    check({tag, " b.coils"},     32'(bus_b.coils),     32'(m_coils[1]));
    check({tag, " b.energized"}, 32'(bus_b.energized), 32'(m_en[1]));
    check({tag, " b.step_done"}, 32'(bus_b.step_done), 32'(m_done[1]));
    check({tag, " b.position"},  32'(bus_b.position),  32'(m_pos[1]));
  endtask

  // Inputs change at negedge; model advances on the same posedge as the DUTs.
  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  logic [3:0] hit_coils_a;
  logic       hit_done_a;

  task automatic pulse(input logic dir, input logic full, input string tag);
    s_dir = dir; s_full = full; s_step = 1'b1;
    tick(tag);
    hit_coils_a = bus_a.coils;
    hit_done_a  = bus_a.step_done;
    s_step = 1'b0;
    tick(tag);
  endtask

  task automatic do_reset();
    s_step = 1'b0;
    rst    = 1'b0;
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [3:0] seq_fwd_half [9] = '{4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100,
                                   4'b1000, 4'b1001, 4'b0001, 4'b0011};
  logic [3:0] seq_rev_full [3] = '{4'b1000, 4'b0100, 4'b0010};

  initial begin
    rst = 1'b0; s_step = 1'b0; s_dir = 1'b1; s_full = 1'b0; s_enable = 1'b1;
    model_reset();
    #1;
    compare_all("por");

    // Forward half steps through the full table and one beyond.
    do_reset();
    s_enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pulse(1'b1, 1'b0, "fwd_half");
      check("fwd_half seq coils", 32'(hit_coils_a), 32'(seq_fwd_half[i]));
      check("fwd_half seq done",  32'(hit_done_a),  32'd1);
    end
    check("fwd_half position", 32'(bus_a.position), 32'd9);

    // Reverse full steps from reset: phases 6,4,2.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b1, "rev_full");
      check("rev_full seq coils", 32'(hit_coils_a), 32'(seq_rev_full[i]));
    end
    check("rev_full position", 32'(bus_a.position), 32'h0000_FFFA);

    // Idle timeout on dut_a (10 cycles); dut_b has it disabled.
    do_reset();
    pulse(1'b1, 1'b0, "idle_step");
    for (int i = 0; i < 8; i++) tick("idle_wait");
    check("idle held coils", 32'(bus_a.coils), 32'b0011);
    tick("idle_expire");
    check("idle off coils",     32'(bus_a.coils),     32'd0);
    check("idle off energized", 32'(bus_a.energized), 32'd0);
    check("idle b still on",    32'(bus_b.coils),     32'b0011);
    pulse(1'b1, 1'b0, "idle_resume");
    check("idle resume coils",    32'(bus_a.coils),    32'b0010);
    check("idle resume position", 32'(bus_a.position), 32'd2);

    // enable drop coincident with a step edge, then step held across re-enable.
    s_enable = 1'b0; s_step = 1'b1;
    tick("en_drop");
    check("en_drop coils",    32'(bus_a.coils),     32'd0);
    check("en_drop position", 32'(bus_a.position),  32'd2);
    check("en_drop done",     32'(bus_a.step_done), 32'd0);
    s_enable = 1'b1;
    tick("en_rise_held");
    check("en_rise_held done",  32'(bus_a.step_done), 32'd0);
    check("en_rise_held coils", 32'(bus_a.coils),     32'd0);
    s_step = 1'b0;
    tick("en_release");
    pulse(1'b1, 1'b0, "en_after");
    check("en_after coils", 32'(bus_a.coils), 32'b0110);

    // Position wrap on the 4-bit instance.
    do_reset();
    for (int i = 0; i < 15; i++) pulse(1'b1, 1'b0, "wrap_run");
    check("wrap b pos pre",   32'(bus_b.position), 32'hF);
    check("wrap b coils pre", 32'(bus_b.coils),    32'b1001);
    pulse(1'b1, 1'b0, "wrap_step");
    check("wrap b pos post",   32'(bus_b.position), 32'h0);
    check("wrap b coils post", 32'(bus_b.coils),    32'b0001);

    // Asynchronous reset mid-motion, between clock edges.
    do_reset();
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, "pre_rst");
    check("pre_rst coils", 32'(bus_a.coils), 32'b1100);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("async rst coils",     32'(bus_a.coils),     32'd0);
    check("async rst position",  32'(bus_a.position),  32'd0);
    check("async rst energized", 32'(bus_a.energized), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pulse(1'b1, 1'b0, "post_rst");
    check("post_rst coils", 32'(bus_a.coils), 32'b0011);

    // Randomised traffic, including quiet stretches that reach the timeout.
    for (int i = 0; i < 300; i++) begin
      s_step   = 1'($urandom_range(0, 1));
      s_dir    = 1'($urandom_range(0, 1));
      s_full   = 1'($urandom_range(0, 1));
      s_enable = ($urandom_range(0, 7) != 0);
      tick("random");
      if ($urandom_range(0, 15) == 0) begin
        s_step = 1'b0; s_enable = 1'b1;
        for (int j = 0; j < 12; j++) tick("random_quiet");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
